multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Sequencing FSM for the multi-cycle RV32I core. Fetch and data accesses share one single-port memory with a req/ready handshake.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the datapath enables and mux selects per state.
- Traps on illegal opcodes and on memory timeouts.
- Counts retired instructions for the lab's CPI measurements.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles mem_req may stay high without mem_ready; reaching it triggers a trap.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  single core clock.
- rst_n  in  1  asynchronous active-low reset.
- Opcode  in  7  opcode field from the instruction register; valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- IorD  out  1  memory address select: 0 = PC, 1 = ALU result.
- MemRead  out  1  read access.
- MemWrite  out  1  write access.
- IRWrite  out  1  load the instruction register.
- PCWrite  out  1  update the PC; one pulse per retired instruction.
- Branch  out  1  PC mux selects the branch/jump target; the datapath gates BR with its compare result.
- ALUSrc  out  1  ALU operand B: 0 = rs2, 1 = immediate.
- ALUOp  out  3  ALU operation class.
- RegWrite  out  1  register file write enable.
- MemtoReg  out  1  write-back source: 0 = ALU, 1 = memory data.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  fault cause: 01 = illegal opcode, 10 = memory timeout.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- **Reset:** async, rst_n low. State = FETCH, op_q = 0, timeout counter = 0, instret = 0, trap = 0, trap_cause = 00. Every output defaults to 0, except that FETCH drives its Moore outputs once reset is released.
- **Outputs:** Moore, decoded from state and op_q. The only exception is IRWrite, which equals mem_ready in FETCH.
- **Opcodes:**
  - R = 0110011, I-ALU = 0010011, LW = 0000011, SW = 0100011, BR = 1100011.
  - JAL = 1101111, JALR = 1100111, LUI = 0110111, AUIPC = 0010111.
  - Any other value is illegal.
- **ALUOp** (driven in EXEC, MEM and WB; 000 otherwise):
  - R 000, SW 001, I 010, LW 011, BR 100, AUIPC/LUI 101, JAL 110, JALR 111.
  - ALUSrc = 1 for every opcode except R and BR.
- **FETCH:** mem_req = 1, MemRead = 1, IorD = 0. When mem_ready = 1: IRWrite = 1 and go to DECODE. Otherwise stay.
- **DECODE:** op_q <= Opcode. If the opcode is illegal, go to TRAP with cause 01. Otherwise go to EXEC.
- **EXEC:**
  - BR/JAL/JALR: Branch = 1.
  - BR: PCWrite = 1, instret++, go to FETCH.
  - LW/SW: go to MEM.
  - All others: go to WB.
- **MEM:** mem_req = 1, IorD = 1, MemRead = (LW), MemWrite = (SW). When mem_ready = 1:
  - LW: go to WB.
  - SW: PCWrite = 1, instret++, go to FETCH.
- **WB:** RegWrite = 1, MemtoReg = (LW), PCWrite = 1, instret++, go to FETCH. Branch = 1 for JAL/JALR, so the PC takes the target while rd receives the link value.
- **Handshake:**
  - mem_req stays high with stable IorD, MemRead and MemWrite until mem_ready.
  - mem_ready is ignored while mem_req = 0.
  - mem_ready in the same cycle as the request is legal (zero wait states).
- **Timeout:**
  - The counter increments each cycle mem_req = 1 && mem_ready = 0, and clears on mem_ready or when leaving the state.
  - When the counter reaches MEM_TIMEOUT-1 with mem_ready still 0, the FSM goes to TRAP with cause 10 on the next edge.
  - mem_ready arriving in that same cycle wins: no trap.
- **TRAP:** all datapath outputs are 0 and trap = 1. The state is absorbing until reset.
- **Latency with zero wait states:**
  - BR: 3 cycles.
  - R, I, LUI, AUIPC, JAL, JALR, SW: 4 cycles.
  - LW: 5 cycles.
  - Each wait state adds 1 cycle.
- **instret:** wraps modulo 2^CNT_W.
- **Reset mid-operation:** rst_n asserted in any state immediately returns everything to reset values; mem_req drops asynchronously.

Test Plan:
- Reset released with mem_ready = 1 and an R-type (0110011) presented → FETCH, DECODE, EXEC, WB in 4 cycles. RegWrite = 1 and PCWrite = 1 only in WB; ALUOp = 000 in EXEC; instret = 1.
- LW with mem_ready delayed 2 cycles in both FETCH and MEM → 9 cycles total. MemtoReg = 1 in WB; IorD = 1 held for 3 MEM cycles; mem_req never drops before ready.
- Sequence SW, BR, JAL → SW: MemWrite = 1 in MEM and no RegWrite. BR: Branch = 1 and PCWrite = 1 in EXEC, 3 cycles. JAL: Branch = 1 with RegWrite = 1 in WB, ALUOp = 110. instret = 3.
- Opcode = 1111111 → TRAP after DECODE, trap = 1, trap_cause = 01. No PCWrite, RegWrite or mem_req afterwards; instret unchanged.
- MEM_TIMEOUT = 4, mem_ready held 0 in FETCH → trap_cause = 10 after 4 request cycles. Repeat with mem_ready on the 4th cycle → no trap, FSM goes to DECODE.
- rst_n pulsed low during the MEM wait of an SW → mem_req and MemWrite drop immediately; after release the FSM is in FETCH with instret = 0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// ============================================================================
// Module      : multicycle_controller_if
// Description : Single-port memory request/ready handshake shared by
//               instruction fetch and data access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_controller_if;
    logic mem_req;
    logic mem_ready;
    logic IorD;
    logic MemRead;
    logic MemWrite;

    modport master (
        output mem_req,
        output IorD,
        output MemRead,
        output MemWrite,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  IorD,
        input  MemRead,
        input  MemWrite,
        output mem_ready
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module      : multicycle_controller
// Description : FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle RV32I
//               core with trap handling and a retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    multicycle_controller_if.master mem,
    input  wire logic [6:0]         Opcode,
    output logic                    IRWrite,
    output logic                    PCWrite,
    output logic                    Branch,
    output logic                    ALUSrc,
    output logic [2:0]              ALUOp,
    output logic                    RegWrite,
    output logic                    MemtoReg,
    output logic                    trap,
    output logic [1:0]              trap_cause,
    output logic [CNT_W-1:0]        instret
);

    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_LW    = 7'b0000011;
    localparam logic [6:0] c_OP_SW    = 7'b0100011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

    localparam int               c_TO_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] c_CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] c_CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [6:0]          r_op;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic [CNT_W-1:0]    r_instret;
    logic                r_trap;
    logic [1:0]          r_cause;

    logic                w_mem_req;
    logic                w_iord;
    logic                w_mrd;
    logic                w_mwr;
    logic                w_irw;
    logic                w_pcw;
    logic                w_br;
    logic                w_asrc;
    logic [2:0]          w_aop;
    logic                w_rw;
    logic                w_m2r;
    logic                w_trap_set;
    logic [1:0]          w_cause;
    logic                w_wait;
    logic                w_expire;
    logic [2:0]          w_aop_dec;
    logic                w_src_dec;
    logic                w_is_lw;
    logic                w_is_sw;
    logic                w_is_jump;

    function automatic logic f_legal(input logic [6:0] op);
        case (op)
            c_OP_R, c_OP_I, c_OP_LW, c_OP_SW, c_OP_BR,
            c_OP_JAL, c_OP_JALR, c_OP_LUI, c_OP_AUIPC: f_legal = 1'b1;
            default:                                   f_legal = 1'b0;
        endcase
    endfunction

    always_comb begin
        w_aop_dec = 3'b000;
        case (r_op)
            c_OP_R:               w_aop_dec = 3'b000;
            c_OP_SW:              w_aop_dec = 3'b001;
            c_OP_I:               w_aop_dec = 3'b010;
            c_OP_LW:              w_aop_dec = 3'b011;
            c_OP_BR:              w_aop_dec = 3'b100;
            c_OP_AUIPC, c_OP_LUI: w_aop_dec = 3'b101;
            c_OP_JAL:             w_aop_dec = 3'b110;
            c_OP_JALR:            w_aop_dec = 3'b111;
            default:              w_aop_dec = 3'b000;
        endcase
    end

    assign w_src_dec = !((r_op == c_OP_R) || (r_op == c_OP_BR));
    assign w_is_lw   = (r_op == c_OP_LW);
    assign w_is_sw   = (r_op == c_OP_SW);
    assign w_is_jump = (r_op == c_OP_JAL) || (r_op == c_OP_JALR);

    // The timeout watchdog only sees cycles where a request is outstanding.
    assign w_wait   = w_mem_req && !mem.mem_ready;
    assign w_expire = w_wait && (r_to_cnt == c_TO_LAST);

    always_comb begin
        w_next     = r_state;
        w_mem_req  = 1'b0;
        w_iord     = 1'b0;
        w_mrd      = 1'b0;
        w_mwr      = 1'b0;
        w_irw      = 1'b0;
        w_pcw      = 1'b0;
        w_br       = 1'b0;
        w_asrc     = 1'b0;
        w_aop      = 3'b000;
        w_rw       = 1'b0;
        w_m2r      = 1'b0;
        w_trap_set = 1'b0;
        w_cause    = 2'b00;

        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                w_mrd     = 1'b1;
                if (mem.mem_ready) begin
                    w_irw  = 1'b1;
                    w_next = S_DECODE;
                end else if (w_expire) begin
                    w_trap_set = 1'b1;
                    w_cause    = c_CAUSE_TIMEOUT;
                    w_next     = S_TRAP;
                end
            end

            S_DECODE: begin
                if (!f_legal(Opcode)) begin
                    w_trap_set = 1'b1;
                    w_cause    = c_CAUSE_ILLEGAL;
                    w_next     = S_TRAP;
                end else begin
                    w_next = S_EXEC;
                end
            end

            S_EXEC: begin
                w_asrc = w_src_dec;
                w_aop  = w_aop_dec;
                w_br   = (r_op == c_OP_BR) || w_is_jump;
                if (r_op == c_OP_BR) begin
                    w_pcw  = 1'b1;
                    w_next = S_FETCH;
                end else if (w_is_lw || w_is_sw) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end

            S_MEM: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                w_mrd     = w_is_lw;
                w_mwr     = w_is_sw;
                w_asrc    = w_src_dec;
                w_aop     = w_aop_dec;
                if (mem.mem_ready) begin
                    if (w_is_lw) begin
                        w_next = S_WB;
                    end else begin
                        // Stores retire on completion; gating on ready keeps PCWrite to one pulse.
                        w_pcw  = 1'b1;
                        w_next = S_FETCH;
                    end
                end else if (w_expire) begin
                    w_trap_set = 1'b1;
                    w_cause    = c_CAUSE_TIMEOUT;
                    w_next     = S_TRAP;
                end
            end

            S_WB: begin
                w_rw   = 1'b1;
                w_m2r  = w_is_lw;
                w_pcw  = 1'b1;
                w_br   = w_is_jump;
                w_asrc = w_src_dec;
                w_aop  = w_aop_dec;
                w_next = S_FETCH;
            end

            S_TRAP: begin
                w_next = S_TRAP;
            end

            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_op      <= 7'd0;
            r_to_cnt  <= '0;
            r_instret <= '0;
            r_trap    <= 1'b0;
            r_cause   <= 2'b00;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op <= Opcode;
            end
            r_to_cnt <= (w_wait && !w_expire) ? r_to_cnt + 1'b1 : '0;
            if (w_pcw) begin
                r_instret <= r_instret + 1'b1;
            end
            if (w_trap_set) begin
                r_trap  <= 1'b1;
                r_cause <= w_cause;
            end
        end
    end

    // Outputs are forced low while reset is held so FETCH does not request early.
    assign mem.mem_req  = rst_n & w_mem_req;
    assign mem.IorD     = rst_n & w_iord;
    assign mem.MemRead  = rst_n & w_mrd;
    assign mem.MemWrite = rst_n & w_mwr;
    assign IRWrite      = rst_n & w_irw;
    assign PCWrite      = rst_n & w_pcw;
    assign Branch       = rst_n & w_br;
    assign ALUSrc       = rst_n & w_asrc;
    assign ALUOp        = {3{rst_n}} & w_aop;
    assign RegWrite     = rst_n & w_rw;
    assign MemtoReg     = rst_n & w_m2r;
    assign trap         = r_trap;
    assign trap_cause   = r_cause;
    assign instret      = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Directed cycle-by-cycle check of the multicycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

    logic        clk;
    logic        rst_n;
    logic [6:0]  Opcode;
    logic        IRWrite, PCWrite, Branch, ALUSrc, RegWrite, MemtoReg, trap;
    logic [2:0]  ALUOp;
    logic [1:0]  trap_cause;
    logic [31:0] instret;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_controller_if bus ();

    multicycle_controller #(
        .MEM_TIMEOUT (4),
        .CNT_W       (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem        (bus.master),
        .Opcode     (Opcode),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .Branch     (Branch),
        .ALUSrc     (ALUSrc),
        .ALUOp      (ALUOp),
        .RegWrite   (RegWrite),
        .MemtoReg   (MemtoReg),
        .trap       (trap),
        .trap_cause (trap_cause),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mem_req,IorD,MemRead,MemWrite,IRWrite,PCWrite,Branch,ALUSrc,ALUOp,RegWrite,MemtoReg,trap,trap_cause}
    function automatic logic [15:0] ev(input logic mreq, input logic iord, input logic mrd,
                                       input logic mwr, input logic irw, input logic pcw,
                                       input logic br, input logic asrc, input logic [2:0] aop,
                                       input logic rw, input logic m2r, input logic trp,
                                       input logic [1:0] cause);
        ev = {mreq, iord, mrd, mwr, irw, pcw, br, asrc, aop, rw, m2r, trp, cause};
    endfunction

    function automatic logic [15:0] outs();
        outs = {bus.mem_req, bus.IorD, bus.MemRead, bus.MemWrite, IRWrite, PCWrite,
                Branch, ALUSrc, ALUOp, RegWrite, MemtoReg, trap, trap_cause};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drive mem_ready, check outputs, advance one cycle.
    task automatic cyc(input string tag, input logic rdy, input logic [15:0] exp);
        bus.mem_ready = rdy;
        #1;
        chk(tag, {16'd0, outs()}, {16'd0, exp});
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_outs"}, {16'd0, outs()}, 32'd0);
        chk({tag, "_instret"}, instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [15:0] c_F_RDY  = 16'b1010_1000_0000_0000;
    localparam logic [15:0] c_F_WAIT = 16'b1010_0000_0000_0000;

    initial begin
        rst_n         = 1'b0;
        bus.mem_ready = 1'b0;
        Opcode        = 7'd0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {16'd0, outs()}, 32'd0);
        chk("reset_instret", instret, 32'd0);
        rst_n = 1'b1;

        // R-type, zero wait states
        Opcode = 7'b0110011;
        cyc("r_fetch", 1'b1, ev(1,0,1,0,1,0,0,0,3'b000,0,0,0,2'b00));
        cyc("r_decode", 1'b1, 16'd0);
        cyc("r_exec", 1'b1, 16'd0);
        cyc("r_wb", 1'b1, ev(0,0,0,0,0,1,0,0,3'b000,1,0,0,2'b00));
        chk("r_instret", instret, 32'd1);

        // LW, two wait states in FETCH and in MEM
        Opcode = 7'b0000011;
        cyc("lw_f1", 1'b0, ev(1,0,1,0,0,0,0,0,3'b000,0,0,0,2'b00));
        cyc("lw_f2", 1'b0, ev(1,0,1,0,0,0,0,0,3'b000,0,0,0,2'b00));
        cyc("lw_f3", 1'b1, ev(1,0,1,0,1,0,0,0,3'b000,0,0,0,2'b00));
        cyc("lw_decode", 1'b0, 16'd0);
        cyc("lw_exec", 1'b0, ev(0,0,0,0,0,0,0,1,3'b011,0,0,0,2'b00));
        cyc("lw_m1", 1'b0, ev(1,1,1,0,0,0,0,1,3'b011,0,0,0,2'b00));
        cyc("lw_m2", 1'b0, ev(1,1,1,0,0,0,0,1,3'b011,0,0,0,2'b00));
        cyc("lw_m3", 1'b1, ev(1,1,1,0,0,0,0,1,3'b011,0,0,0,2'b00));
        cyc("lw_wb", 1'b0, ev(0,0,0,0,0,1,0,1,3'b011,1,1,0,2'b00));
        chk("lw_instret", instret, 32'd2);

        // SW
        Opcode = 7'b0100011;
        cyc("sw_fetch", 1'b1, c_F_RDY);
        cyc("sw_decode", 1'b1, 16'd0);
        cyc("sw_exec", 1'b1, ev(0,0,0,0,0,0,0,1,3'b001,0,0,0,2'b00));
        cyc("sw_mem", 1'b1, ev(1,1,0,1,0,1,0,1,3'b001,0,0,0,2'b00));
        chk("sw_instret", instret, 32'd3);

        // BR
        Opcode = 7'b1100011;
        cyc("br_fetch", 1'b1, c_F_RDY);
        cyc("br_decode", 1'b1, 16'd0);
        cyc("br_exec", 1'b1, ev(0,0,0,0,0,1,1,0,3'b100,0,0,0,2'b00));
        chk("br_instret", instret, 32'd4);

        // JAL
        Opcode = 7'b1101111;
        cyc("jal_fetch", 1'b1, c_F_RDY);
        cyc("jal_decode", 1'b1, 16'd0);
        cyc("jal_exec", 1'b1, ev(0,0,0,0,0,0,1,1,3'b110,0,0,0,2'b00));
        cyc("jal_wb", 1'b1, ev(0,0,0,0,0,1,1,1,3'b110,1,0,0,2'b00));
        chk("jal_instret", instret, 32'd5);

        // Illegal opcode
        Opcode = 7'b1111111;
        cyc("ill_fetch", 1'b1, c_F_RDY);
        cyc("ill_decode", 1'b1, 16'd0);
        cyc("ill_trap1", 1'b1, ev(0,0,0,0,0,0,0,0,3'b000,0,0,1,2'b01));
        cyc("ill_trap2", 1'b1, ev(0,0,0,0,0,0,0,0,3'b000,0,0,1,2'b01));
        cyc("ill_trap3", 1'b0, ev(0,0,0,0,0,0,0,0,3'b000,0,0,1,2'b01));
        chk("ill_instret", instret, 32'd5);
        do_reset("rst_after_ill");

        // Fetch timeout with MEM_TIMEOUT = 4
        Opcode = 7'b0110011;
        cyc("to_w1", 1'b0, c_F_WAIT);
        cyc("to_w2", 1'b0, c_F_WAIT);
        cyc("to_w3", 1'b0, c_F_WAIT);
        cyc("to_w4", 1'b0, c_F_WAIT);
        cyc("to_trap", 1'b1, ev(0,0,0,0,0,0,0,0,3'b000,0,0,1,2'b10));
        do_reset("rst_after_to");

        // Ready on the last allowed cycle wins
        cyc("late_w1", 1'b0, c_F_WAIT);
        cyc("late_w2", 1'b0, c_F_WAIT);
        cyc("late_w3", 1'b0, c_F_WAIT);
        cyc("late_rdy", 1'b1, c_F_RDY);
        cyc("late_decode", 1'b0, 16'd0);
        cyc("late_exec", 1'b0, 16'd0);
        cyc("late_wb", 1'b0, ev(0,0,0,0,0,1,0,0,3'b000,1,0,0,2'b00));
        chk("late_instret", instret, 32'd1);
        do_reset("rst_before_sw");

        // Reset pulsed during SW memory wait
        Opcode = 7'b0100011;
        cyc("swr_fetch", 1'b1, c_F_RDY);
        cyc("swr_decode", 1'b0, 16'd0);
        cyc("swr_exec", 1'b0, ev(0,0,0,0,0,0,0,1,3'b001,0,0,0,2'b00));
        cyc("swr_mwait1", 1'b0, ev(1,1,0,1,0,0,0,1,3'b001,0,0,0,2'b00));
        bus.mem_ready = 1'b0;
        #1;
        chk("swr_mwait2", {16'd0, outs()}, {16'd0, ev(1,1,0,1,0,0,0,1,3'b001,0,0,0,2'b00)});
        #1;
        rst_n = 1'b0;
        #1;
        chk("swr_async_drop", {16'd0, outs()}, 32'd0);
        chk("swr_instret_rst", instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("swr_refetch", 1'b0, c_F_WAIT);
        chk("swr_instret_after", instret, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
